slc3_mem_responder: RTL and testbench

- Memory-side responder for the SLC-3 CPU control unit. It services the CPU's mem_mem_ena/mem_wr_ena requests.
- Contains a synchronous single-port program/data RAM with a fixed, parameterised read latency that matches the CPU's wait-state count.
- Adds memory-mapped I/O at 0xFFFF: reads return the switches, writes set the hex-display register.
- Sits between the CPU datapath (MAR/MDR) and the on-board BRAM and I/O.

---
 rtl/slc3_pkg.sv | 27 ++
 rtl/slc3_mem_responder_if.sv | 40 ++++
 rtl/slc3_bram.sv | 50 +++++
 rtl/slc3_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_slc3_mem_responder.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/slc3_pkg.sv
// Shared SLC-3 memory-system definitions: the MMIO address used for the
// switch/hex-display port, the responder state type, the default read
// latency (the control unit's wait-state count is derived from the same
// constant) and a helper that classifies an address as backed by RAM.
package slc3_pkg;

  // Single MMIO location: reads return the board switches, writes load the
  // hex-display register.
  localparam logic [15:0] MMIO_SW_HEX_ADDR = 16'hFFFF;

  // Cycles from request acceptance to mem_rvalid. The CPU's wait states
  // are sized from this value, so both sides must agree.
  localparam int READ_LAT_DEFAULT = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } mem_resp_state_t;

  // True when addr falls inside a RAM of 2**addr_w words.
  function automatic logic addr_in_ram(input logic [15:0] addr, input int addr_w);
    logic [31:0] upper_s;
    upper_s = {16'h0000, addr} >> addr_w;
    return (upper_s == 32'd0);
  endfunction

endpackage

// File: rtl/slc3_mem_responder_if.sv
// CPU <-> memory-responder bus.
//   mem_mem_ena  : operation enable from the control unit (level, rising edge = request)
//   mem_wr_ena   : write select, sampled when a request is accepted
//   mem_addr     : address from MAR
//   mem_wdata    : write data from MDR
//   mem_rdata    : read data toward the MDR input mux (held between reads)
//   mem_rvalid   : one-cycle pulse marking a completed read
//   mem_busy     : high while a read is in flight
// master = CPU side, slave = memory responder side.
interface slc3_mem_responder_if;

  logic        mem_mem_ena;
  logic        mem_wr_ena;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_busy;

  modport master (
    output mem_mem_ena,
    output mem_wr_ena,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_rvalid,
    input  mem_busy
  );

  modport slave (
    input  mem_mem_ena,
    input  mem_wr_ena,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_rvalid,
    output mem_busy
  );

endinterface

// File: rtl/slc3_bram.sv
// Single-port synchronous RAM, 16-bit words, 2**ADDR_W deep.
// The address is registered every cycle and the read data passes through an
// output register that only loads when rd_en is high, so data appears two
// cycles after the address is presented and then holds.
//   clk   : clock
//   we    : write strobe, writes wdata to addr on this edge
//   rd_en : load the output register from the registered address
//   addr  : word address
//   wdata : write data
//   rdata : output register
module slc3_bram #(
  parameter int ADDR_W    = 10,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [15:0]       mem_r [0:DEPTH-1];
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       rdata_r;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Address register, loaded every cycle.
  always_ff @(posedge clk) begin
    addr_r <= addr;
  end

  // Output register; holds its value when rd_en is low.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rdata_r <= mem_r[addr_r];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3 control unit. Accepts one request per
// rising edge of mem_mem_ena while idle. Writes complete at the acceptance
// edge (RAM or hex-display register); reads complete after READ_LAT cycles
// with a single mem_rvalid pulse. Address 0xFFFF is memory-mapped I/O.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   mem   : CPU bus (slave side), see slc3_mem_responder_if
//   sw_i  : board switches, returned by reads of 0xFFFF
//   hex_o : hex-display register, loaded by writes to 0xFFFF
module slc3_mem_responder
  import slc3_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = READ_LAT_DEFAULT,
  parameter     INIT_FILE = ""
) (
  input  logic                       clk,
  input  logic                       reset,
  slc3_mem_responder_if.slave        mem,
  input  logic [15:0]                sw_i,
  output logic [15:0]                hex_o
);

  localparam int              CNT_W    = $clog2(READ_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  mem_resp_state_t   state_r, state_n_s;
  logic [CNT_W-1:0]  cnt_r, cnt_n_s;
  logic              busy_r, busy_n_s;
  logic              rvalid_r, rvalid_n_s;
  logic              last_s;
  logic              ena_q_r;
  logic              accept_s, rd_accept_s, wr_accept_s;
  logic [15:0]       lat_addr_r;
  logic [15:0]       hex_r;
  logic              rdata_from_ram_r;
  logic [15:0]       local_rdata_r;
  logic [ADDR_W-1:0] bram_addr_s;
  logic              bram_we_s;
  logic [15:0]       bram_rdata_s;

  // Request detection: a rising edge of enable while idle. Holding enable
  // through the CPU wait states therefore counts once.
  always_comb begin
    accept_s    = (state_r == IDLE) && mem.mem_mem_ena && !ena_q_r;
    wr_accept_s = accept_s && mem.mem_wr_ena;
    rd_accept_s = accept_s && !mem.mem_wr_ena;
  end

  // Next state, countdown and output strobes. The counter is loaded with
  // READ_LAT-1 and the result is registered on the edge where it steps from
  // 1 to 0, so rvalid lands in the cycle the counter reads 0; the FSM then
  // leaves RD_WAIT at the end of that cycle.
  always_comb begin
    state_n_s  = state_r;
    cnt_n_s    = cnt_r;
    busy_n_s   = 1'b0;
    rvalid_n_s = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (rd_accept_s) begin
          state_n_s = RD_WAIT;
          cnt_n_s   = CNT_LOAD;
          busy_n_s  = 1'b1;
        end else begin
          state_n_s = IDLE;
          cnt_n_s   = CNT_ZERO;
        end
      end
      RD_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_n_s = IDLE;
        end else begin
          cnt_n_s = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            rvalid_n_s = 1'b1;
            last_s     = 1'b1;
          end else begin
            busy_n_s = 1'b1;
          end
        end
      end
      default: begin
        state_n_s = IDLE;
        cnt_n_s   = CNT_ZERO;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      busy_r   <= 1'b0;
      rvalid_r <= 1'b0;
      ena_q_r  <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      cnt_r    <= cnt_n_s;
      busy_r   <= busy_n_s;
      rvalid_r <= rvalid_n_s;
      ena_q_r  <= mem.mem_mem_ena;
    end
  end

  // Datapath registers: latched read address, hex display and the read
  // result. RAM data stays in the BRAM output register; only the source
  // select and the MMIO/zero value live here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_addr_r       <= 16'h0000;
      hex_r            <= 16'h0000;
      rdata_from_ram_r <= 1'b0;
      local_rdata_r    <= 16'h0000;
    end else begin
      if (rd_accept_s) begin
        lat_addr_r <= mem.mem_addr;
      end
      if (wr_accept_s && (mem.mem_addr == MMIO_SW_HEX_ADDR)) begin
        hex_r <= mem.mem_wdata;
      end
      if (last_s) begin
        rdata_from_ram_r <= addr_in_ram(lat_addr_r, ADDR_W);
        if (lat_addr_r == MMIO_SW_HEX_ADDR) begin
          local_rdata_r <= sw_i;
        end else begin
          local_rdata_r <= 16'h0000;
        end
      end
    end
  end

  // While idle the BRAM sees the live bus address (so its address register
  // already holds the read address one cycle after acceptance); during a
  // read it keeps seeing the latched copy.
  always_comb begin
    if (state_r == IDLE) begin
      bram_addr_s = mem.mem_addr[ADDR_W-1:0];
    end else begin
      bram_addr_s = lat_addr_r[ADDR_W-1:0];
    end
    bram_we_s = wr_accept_s && addr_in_ram(mem.mem_addr, ADDR_W);
  end

  slc3_bram #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_bram (
    .clk   (clk),
    .we    (bram_we_s),
    .rd_en (last_s),
    .addr  (bram_addr_s),
    .wdata (mem.mem_wdata),
    .rdata (bram_rdata_s)
  );

  assign mem.mem_rdata  = rdata_from_ram_r ? bram_rdata_s : local_rdata_r;
  assign mem.mem_rvalid = rvalid_r;
  assign mem.mem_busy   = busy_r;
  assign hex_o          = hex_r;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Bench for slc3_mem_responder: directed scenarios followed by random
// reads/writes. A driver issues requests and pushes expected read results
// (from a word-array memory model) into a scoreboard; a monitor on the
// falling edge pops and compares on every rvalid and checks hold, busy and
// the hex display every cycle.
module tb_slc3_mem_responder;

  localparam int ADDR_W   = 10;
  localparam int READ_LAT = 3;
  localparam int DEPTH    = 2 ** ADDR_W;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ena = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] sw = 16'h0000;
  logic [15:0] hex_o;

  slc3_mem_responder_if mem_if ();

  assign mem_if.mem_mem_ena = ena;
  assign mem_if.mem_wr_ena  = wr;
  assign mem_if.mem_addr    = addr;
  assign mem_if.mem_wdata   = wdata;

  slc3_mem_responder #(
    .ADDR_W   (ADDR_W),
    .READ_LAT (READ_LAT),
    .INIT_FILE("")
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mem   (mem_if),
    .sw_i  (sw),
    .hex_o (hex_o)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          total_cnt = 0;
  int          pass_cnt = 0;
  bit          mon_en = 1'b0;
  exp_t        sb[$];
  logic [15:0] ram_m [0:DEPTH-1];
  logic [15:0] hex_exp = 16'h0000;
  logic [15:0] last_rdata = 16'h0000;
  int          last_rv_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a == 16'hFFFF) return sw;
    else if (a < DEPTH) return ram_m[a[ADDR_W-1:0]];
    else return 16'h0000;
  endfunction

  // Monitor: scoreboard pops on rvalid; hold/busy/hex checked every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      bit   exp_busy;
      exp_t e;
      exp_busy = (sb.size() != 0) && (cyc < sb[0].cyc);
      chk("busy", 32'(mem_if.mem_busy), 32'(exp_busy));
      chk("hex_o", 32'(hex_o), 32'(hex_exp));
      if (mem_if.mem_rvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", 32'(mem_if.mem_rvalid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rdata", 32'(mem_if.mem_rdata), 32'(e.data));
          chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
          last_rdata  = e.data;
          last_rv_cyc = cyc;
        end
      end else begin
        chk("rdata_hold", 32'(mem_if.mem_rdata), 32'(last_rdata));
      end
    end
  end

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    ena = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    if (a == 16'hFFFF) hex_exp = d;
    else if (a < DEPTH) ram_m[a[ADDR_W-1:0]] = d;
    @(negedge clk);
    ena = 1'b0; wr = 1'b0;
  endtask

  // hold==0 keeps enable high until the rvalid cycle (CPU-style); otherwise
  // enable is high for 'hold' cycles counting the request cycle. The bus
  // address switches to 'alt' one cycle into the read. 'spur' raises enable
  // again in the rvalid cycle, which must be ignored.
  task automatic do_read(input logic [15:0] a, input int hold,
                         input logic [15:0] alt, input bit spur);
    exp_t e;
    bit   high;
    int   guard;
    @(negedge clk);
    ena = 1'b1; wr = 1'b0; addr = a; wdata = 16'($urandom);
    @(posedge clk); #1;
    e.data = model_read(a);
    e.cyc  = cyc + READ_LAT - 1;
    sb.push_back(e);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 1) addr = alt;
      if (hold == 0) high = (cyc <= e.cyc);
      else high = (i + 1 < hold);
      if (spur && (i == READ_LAT - 1 || i == READ_LAT)) high = 1'b1;
      ena = high;
      if (!high && (!spur || i > READ_LAT)) break;
    end
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      chk("read_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  function automatic logic [15:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0:       return 16'hFFFF;
      1:       return 16'h03FF;
      2:       return 16'h0000;
      3:       return 16'($urandom_range(DEPTH, 65534));
      4, 5, 6: return 16'($urandom_range(0, 15));
      7, 8:    return 16'($urandom_range(DEPTH - 16, DEPTH - 1));
      default: return 16'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1;
    exp_t e;
    logic [15:0] a;
    for (int i = 0; i < DEPTH; i++) ram_m[i] = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_rdata", 32'(mem_if.mem_rdata), 32'h0);
    chk("reset_rvalid", 32'(mem_if.mem_rvalid), 32'h0);

    // Bring the RAM to a known state.
    for (int i = 0; i < DEPTH; i++) do_write(16'(i), 16'h0000);

    // Write then read, CPU holds enable 3 cycles.
    do_write(16'h0010, 16'h1234);
    do_read(16'h0010, 3, 16'h0010, 1'b0);

    // MMIO.
    do_write(16'hFFFF, 16'hBEEF);
    sw = 16'h00A5;
    do_read(16'hFFFF, 3, 16'hFFFF, 1'b0);

    // Out of range write and read.
    do_write(16'h0400, 16'h5555);
    do_read(16'h0000, 0, 16'h0000, 1'b0);
    do_read(16'h0400, 0, 16'h0400, 1'b0);

    // Held enable with address change mid-read.
    do_write(16'h0020, 16'hAAAA);
    do_write(16'h0021, 16'h5151);
    do_read(16'h0020, 6, 16'h0021, 1'b0);

    // Address wrap, back-to-back reads.
    do_write(16'h03FF, 16'h7E57);
    do_write(16'h0000, 16'h0F0F);
    do_read(16'h03FF, 0, 16'h03FF, 1'b0);
    r1 = last_rv_cyc;
    do_read(16'h0000, 0, 16'h0000, 1'b0);
    chk("b2b_spacing", 32'(last_rv_cyc - r1), 32'(READ_LAT + 2));

    // Enable drops early, then rises again in the rvalid cycle.
    do_read(16'h0010, 1, 16'h0010, 1'b1);

    // Reset in the middle of a read.
    do_write(16'h0005, 16'hCAFE);
    @(negedge clk);
    ena = 1'b1; wr = 1'b0; addr = 16'h0005;
    @(posedge clk); #1;
    e.data = 16'hCAFE; e.cyc = cyc + READ_LAT - 1;
    sb.push_back(e);
    @(negedge clk);
    reset = 1'b0; ena = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    last_rdata = 16'h0000;
    hex_exp = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    do_read(16'h0005, 0, 16'h0005, 1'b0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      a = rand_addr();
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, 16'($urandom));
      end else begin
        sw = 16'($urandom);
        do_read(a, $urandom_range(0, 6), rand_addr(), 1'($urandom_range(0, 3) == 0));
      end
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
